// File: rtl/mont_exp_ladder_pkg.sv
// Shared types and width helpers for the Montgomery-ladder exponentiator.
package mont_exp_ladder_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCapture,
        StToMont,
        StWaitToMont,
        StLadderIssue,
        StLadderWait,
        StFromMont,
        StWaitFromMont,
        StDone
    } state_t;

    // Exponent-length field must hold the value WIDTH itself.
    function automatic int unsigned len_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    // Bit-index / iteration-counter width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mont_exp_ladder_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a * b * 2^-WIDTH mod m.
// One iteration per cycle; done pulses WIDTH cycles after start is sampled.
// A start always reloads the operands, discarding any product still in flight.
module montgomery_mul
    import mont_exp_ladder_pkg::*;
#(
    parameter int unsigned WIDTH = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int unsigned CntW = idx_width(WIDTH);

    logic [WIDTH-1:0] a_q, b_q, m_q, result_q;
    logic [WIDTH:0]   s_q;        // partial sum stays below 2m
    logic [CntW-1:0]  cnt_q;
    logic             running_q, done_q;

    logic [WIDTH+1:0] sum_ab, sum_abm;
    logic [WIDTH:0]   s_next;
    logic [WIDTH-1:0] s_red;

    // One Montgomery step plus the final conditional subtraction.
    always_comb begin
        sum_ab  = {1'b0, s_q} + (a_q[0] ? {2'b00, b_q} : '0);
        sum_abm = sum_ab + (sum_ab[0] ? {2'b00, m_q} : '0);
        s_next  = (WIDTH + 1)'(sum_abm >> 1);
        s_red   = (s_next >= {1'b0, m_q}) ? WIDTH'(s_next - {1'b0, m_q}) : WIDTH'(s_next);
    end

    // Iteration sequencing; start has priority so a stale done can never follow it.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            s_q       <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                a_q       <= in_a;
                b_q       <= in_b;
                m_q       <= in_m;
                s_q       <= '0;
                cnt_q     <= '0;
                running_q <= 1'b1;
            end else if (running_q) begin
                s_q   <= s_next;
                a_q   <= a_q >> 1;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                    result_q  <= s_red;
                end
            end
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: rtl/mont_exp_ladder.sv
// Modular exponentiator x^e mod M using a constant-sequence Montgomery ladder
// over two Montgomery multipliers. Inputs are captured on an accepted start.
module mont_exp_ladder
    import mont_exp_ladder_pkg::*;
#(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned LEN_W = len_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_R_mod_M,
    input  logic [WIDTH-1:0] in_R2_mod_M,
    input  logic [LEN_W-1:0] in_e_length,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned IdxW = idx_width(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] x_q, e_q, m_q, r_q, r2_q;
    logic [LEN_W-1:0] len_q;
    logic [WIDTH-1:0] a_q, xm_q;           // ladder registers A and X (Montgomery form)
    logic [IdxW-1:0]  idx_q;
    logic             bit_q;
    logic             flag0_q, flag1_q;    // sticky per-multiplier completion
    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q;

    logic             mul0_start_q, mul1_start_q;
    logic [WIDTH-1:0] mul0_a_q, mul0_b_q, mul1_a_q, mul1_b_q;
    logic [WIDTH-1:0] mul0_result, mul1_result;
    logic             mul0_done, mul1_done;
    logic             mul0_ok, mul1_ok;
    logic             ladder_bit;

    // A done seen while our own start is still being presented belongs to an
    // older, discarded product.
    assign mul0_ok    = mul0_done && !mul0_start_q;
    assign mul1_ok    = mul1_done && !mul1_start_q;
    assign ladder_bit = e_q[idx_q];

    // Control FSM with registered outputs and multiplier operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            x_q          <= '0;
            e_q          <= '0;
            m_q          <= '0;
            r_q          <= '0;
            r2_q         <= '0;
            len_q        <= '0;
            a_q          <= '0;
            xm_q         <= '0;
            idx_q        <= '0;
            bit_q        <= 1'b0;
            flag0_q      <= 1'b0;
            flag1_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            mul0_start_q <= 1'b0;
            mul1_start_q <= 1'b0;
            mul0_a_q     <= '0;
            mul0_b_q     <= '0;
            mul1_a_q     <= '0;
            mul1_b_q     <= '0;
        end else if (abort) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mul0_start_q <= 1'b0;
            mul1_start_q <= 1'b0;
        end else begin
            mul0_start_q <= 1'b0;
            mul1_start_q <= 1'b0;
            done_q       <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        x_q     <= in_x;
                        e_q     <= in_e;
                        m_q     <= in_m;
                        r_q     <= in_R_mod_M;
                        r2_q    <= in_R2_mod_M;
                        len_q   <= in_e_length;
                        busy_q  <= 1'b1;
                        state_q <= StCapture;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCapture: begin
                    a_q     <= r_q;
                    idx_q   <= IdxW'(len_q - LEN_W'(1));
                    state_q <= (len_q == '0) ? StFromMont : StToMont;
                end
                StToMont: begin
                    mul0_a_q     <= x_q;
                    mul0_b_q     <= r2_q;
                    mul0_start_q <= 1'b1;
                    state_q      <= StWaitToMont;
                end
                StWaitToMont: begin
                    if (mul0_ok) begin
                        xm_q    <= mul0_result;
                        state_q <= StLadderIssue;
                    end
                end
                StLadderIssue: begin
                    bit_q        <= ladder_bit;
                    mul0_a_q     <= a_q;
                    mul0_b_q     <= xm_q;
                    mul1_a_q     <= ladder_bit ? xm_q : a_q;
                    mul1_b_q     <= ladder_bit ? xm_q : a_q;
                    mul0_start_q <= 1'b1;
                    mul1_start_q <= 1'b1;
                    flag0_q      <= 1'b0;
                    flag1_q      <= 1'b0;
                    state_q      <= StLadderWait;
                end
                StLadderWait: begin
                    if (mul0_ok) flag0_q <= 1'b1;
                    if (mul1_ok) flag1_q <= 1'b1;
                    if (flag0_q && flag1_q) begin
                        if (bit_q) begin
                            a_q  <= mul0_result;
                            xm_q <= mul1_result;
                        end else begin
                            xm_q <= mul0_result;
                            a_q  <= mul1_result;
                        end
                        if (idx_q == '0) begin
                            state_q <= StFromMont;
                        end else begin
                            idx_q   <= idx_q - 1'b1;
                            state_q <= StLadderIssue;
                        end
                    end
                end
                StFromMont: begin
                    mul0_a_q     <= a_q;
                    mul0_b_q     <= WIDTH'(1);
                    mul0_start_q <= 1'b1;
                    state_q      <= StWaitFromMont;
                end
                StWaitFromMont: begin
                    if (mul0_ok) begin
                        result_q <= mul0_result;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    montgomery_mul #(
        .WIDTH (WIDTH)
    ) u_mul0 (
        .clk    (clk),
        .reset  (reset),
        .start  (mul0_start_q),
        .in_a   (mul0_a_q),
        .in_b   (mul0_b_q),
        .in_m   (m_q),
        .result (mul0_result),
        .done   (mul0_done)
    );

    montgomery_mul #(
        .WIDTH (WIDTH)
    ) u_mul1 (
        .clk    (clk),
        .reset  (reset),
        .start  (mul1_start_q),
        .in_a   (mul1_a_q),
        .in_b   (mul1_b_q),
        .in_m   (m_q),
        .result (mul1_result),
        .done   (mul1_done)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mont_exp_ladder.sv
// Self-checking bench for mont_exp_ladder at WIDTH=8 against a plain modpow model.
module tb_mont_exp_ladder;
    import mont_exp_ladder_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned LW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [W-1:0]  in_x, in_e, in_m, in_r, in_r2;
    logic [LW-1:0] in_len;
    logic          busy, done;
    logic [W-1:0]  result;

    int errors = 0;
    int checks = 0;
    int mul1_cnt = 0;
    int done_cnt = 0;
    int lat_by_len [0:8];

    always #5 clk = ~clk;

    // Event counters sampled at each active edge.
    always @(posedge clk) begin
        if (dut.u_mul1.start) mul1_cnt <= mul1_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    mont_exp_ladder #(
        .WIDTH (W),
        .LEN_W (LW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .in_x        (in_x),
        .in_e        (in_e),
        .in_m        (in_m),
        .in_R_mod_M  (in_r),
        .in_R2_mod_M (in_r2),
        .in_e_length (in_len),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    // Reference: x^(e mod 2^len) mod m by square-and-multiply.
    function automatic int unsigned ref_modexp(input int unsigned x, input int unsigned e,
                                               input int unsigned len, input int unsigned m);
        longint unsigned r = 1;
        longint unsigned b = x % m;
        for (int i = 0; i < int'(len); i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return int'(r % m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_inputs(input int unsigned x, input int unsigned e,
                               input int unsigned m, input int unsigned len);
        int unsigned rm;
        rm     = (1 << W) % m;
        in_x   = W'(x);
        in_e   = W'(e);
        in_m   = W'(m);
        in_r   = W'(rm);
        in_r2  = W'((rm * rm) % m);
        in_len = LW'(len);
    endtask

    task automatic scramble_inputs();
        in_x   = W'($urandom);
        in_e   = W'($urandom);
        in_m   = W'($urandom);
        in_r   = W'($urandom);
        in_r2  = W'($urandom);
        in_len = LW'($urandom);
    endtask

    // Drives one operation; inputs are scrambled right after capture.
    task automatic run_op(input int unsigned x, input int unsigned e, input int unsigned m,
                          input int unsigned len, output logic [W-1:0] res, output int cyc,
                          output int m1, output int dn, output bit to, output bit gap);
        int m1_0, dn_0;
        load_inputs(x, e, m, len);
        m1_0  = mul1_cnt;
        dn_0  = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_inputs();
        cyc = 1;
        gap = 1'b0;
        while (!done && cyc < 2000) begin
            if (!busy) gap = 1'b1;
            tick();
            cyc++;
        end
        to  = !done;
        res = result;
        tick();
        m1 = mul1_cnt - m1_0;
        dn = done_cnt - dn_0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        scramble_inputs();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
    endtask

    task automatic test_vectors();
        int unsigned xs [5] = '{5, 2, 2, 2, 7};
        int unsigned es [5] = '{3, 5, 5, 8'hF5, 8'hAB};
        int unsigned ls [5] = '{2, 3, 4, 3, 0};
        int unsigned ex [5] = '{8, 6, 6, 6, 1};
        logic [W-1:0] res;
        int cyc, m1, dn;
        bit to, gap;
        for (int i = 0; i < 5; i++) begin
            run_op(xs[i], es[i], 13, ls[i], res, cyc, m1, dn, to, gap);
            checks++;
            if (to) begin errors++; $display("FAIL vec%0d timeout: no done in %0d cycles", i, cyc); end
            checks++;
            if (res !== W'(ex[i])) begin
                errors++; $display("FAIL vec%0d result: got %0d want %0d", i, res, ex[i]);
            end
            checks++;
            if (dn !== 1) begin errors++; $display("FAIL vec%0d done_pulses: got %0d want 1", i, dn); end
            checks++;
            if (m1 !== int'(ls[i])) begin
                errors++; $display("FAIL vec%0d iterations: got %0d want %0d", i, m1, ls[i]);
            end
            checks++;
            if (gap) begin errors++; $display("FAIL vec%0d busy_held: got gap want none", i); end
        end
    endtask

    task automatic test_ignore_start();
        int cyc, dn_0;
        load_inputs(5, 3, 13, 2);
        dn_0  = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 2000) begin
            if (cyc == 5) begin
                load_inputs(2, 5, 11, 3);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (result !== W'(8)) begin
            errors++; $display("FAIL ignore_start result: got %0d want 8", result);
        end
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start idle: busy %b want 0", busy); end
        checks++;
        if (done_cnt - dn_0 !== 1) begin
            errors++; $display("FAIL ignore_start done_pulses: got %0d want 1", done_cnt - dn_0);
        end
    endtask

    task automatic wait_ladder_wait(input string name);
        int n = 0;
        while (dut.state_q != StLadderWait && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL %s reach_ladder: state %0d", name, dut.state_q); end
    endtask

    task automatic test_abort();
        logic [W-1:0] res;
        int cyc, m1, dn, dn_0;
        bit to, gap, seen_done, seen_busy;
        run_op(5, 3, 13, 2, res, cyc, m1, dn, to, gap);
        load_inputs(2, 5, 13, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ladder_wait("abort");
        dn_0  = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        seen_done = 1'b0;
        for (int i = 0; i < 3 * W + 10; i++) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (seen_done || done_cnt != dn_0) begin
            errors++; $display("FAIL abort_no_done: got pulses %0d want 0", done_cnt - dn_0);
        end
        checks++;
        if (result !== W'(8)) begin errors++; $display("FAIL abort_result: got %0d want 8", result); end
        // Abort and start together: abort must win.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (busy) seen_busy = 1'b1;
            tick();
        end
        checks++;
        if (seen_busy) begin errors++; $display("FAIL abort_start_same: busy seen want idle"); end
        run_op(2, 5, 13, 3, res, cyc, m1, dn, to, gap);
        checks++;
        if (to || res !== W'(6)) begin
            errors++; $display("FAIL abort_restart result: got %0d want 6 (timeout %b)", res, to);
        end
    endtask

    task automatic test_reset_mid();
        load_inputs(2, 5, 13, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ladder_wait("reset_mid");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (result !== '0) begin errors++; $display("FAIL reset_mid result: got %0d want 0", result); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b want 0", busy); end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] res;
        int unsigned x, e, m, len, exp_res;
        int cyc, m1, dn;
        bit to, gap;
        for (int i = 0; i <= 8; i++) lat_by_len[i] = -1;
        for (int n = 0; n < 200; n++) begin
            m   = $urandom_range(127, 1) * 2 + 1;
            x   = $urandom % m;
            e   = $urandom & 32'hFF;
            len = $urandom_range(W, 0);
            exp_res = ref_modexp(x, e, len, m);
            run_op(x, e, m, len, res, cyc, m1, dn, to, gap);
            checks++;
            if (to || res !== W'(exp_res)) begin
                errors++;
                $display("FAIL rand%0d result: x=%0d e=%0d len=%0d m=%0d got %0d want %0d",
                         n, x, e, len, m, res, exp_res);
            end
            checks++;
            if (m1 !== int'(len) || dn !== 1) begin
                errors++;
                $display("FAIL rand%0d counts: iters %0d done %0d want %0d and 1", n, m1, dn, len);
            end
            if (lat_by_len[len] < 0) begin
                lat_by_len[len] = cyc;
            end else begin
                checks++;
                if (cyc !== lat_by_len[len]) begin
                    errors++;
                    $display("FAIL rand%0d latency: len=%0d got %0d want %0d",
                             n, len, cyc, lat_by_len[len]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
